// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Write-back arbiter in front of the register file write port. Merges the
//   in-order pipeline write-back stream (P) with long-latency results (L),
//   which are buffered in a small FIFO. It issues at most one register write
//   per cycle and keeps a per-register pending scoreboard for decode stalls.
//
// Ports
//   clk                      system clock, rising edge
//   rst                      asynchronous, active-low reset
//   p_valid/p_waddr/p_wdata  pipeline write-back request (always accepted)
//   l_valid/l_waddr/l_wdata  long-latency request, accepted when l_ready
//   l_ready                  FIFO not full
//   claim_en/claim_addr      decode marks claim_addr as pending
//   raddr1/raddr2            decode source registers to query
//   busy1/busy2              pending bit of raddr1/raddr2
//   we/waddr/wdata           registered regfile write port
//   fifo_level               current FIFO occupancy
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_valid,
    input  logic [ADDR_W-1:0] p_waddr,
    input  logic [DATA_W-1:0] p_wdata,
    input  logic              l_valid,
    output logic              l_ready,
    input  logic [ADDR_W-1:0] l_waddr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic              busy1,
    output logic              busy2,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [PTR_W:0]    fifo_level
);

    localparam int            NREG     = 1 << ADDR_W;
    localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DEPTH);

    // FIFO storage (data only, never reset) and control
    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_level;

    // Registered write port and scoreboard
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [NREG-1:0]   r_pend;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_sel_vld;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_wr_issue;
    logic [NREG-1:0]   w_pend_nxt;

    assign w_empty = (r_level == '0);
    // Full is judged on the current level only; a same-cycle pop does not
    // open a slot for the producer.
    assign w_full  = (r_level == LVL_FULL);
    assign w_push  = l_valid && !w_full;
    // P always wins, so the FIFO head is only consumed in P-idle cycles.
    assign w_pop   = !p_valid && !w_empty;

    always_comb begin
        w_sel_vld  = p_valid || !w_empty;
        w_sel_addr = r_mem_addr[r_rptr];
        w_sel_data = r_mem_data[r_rptr];
        if (p_valid) begin
            w_sel_addr = p_waddr;
            w_sel_data = p_wdata;
        end
    end

    // Register 0 requests are consumed but never reach the regfile.
    assign w_wr_issue = w_sel_vld && (w_sel_addr != '0);

    // Clear first, then set: a claim in the same cycle as the retiring write
    // belongs to a newer instruction and must stay outstanding.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_wr_issue) begin
            w_pend_nxt[w_sel_addr] = 1'b0;
        end
        if (claim_en && (claim_addr != '0)) begin
            w_pend_nxt[claim_addr] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wptr] <= l_waddr;
            r_mem_data[r_wptr] <= l_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Address/data hold their last value on idle and register-0 cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_wr_issue;
            if (w_wr_issue) begin
                r_waddr <= w_sel_addr;
                r_wdata <= w_sel_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign l_ready    = !w_full;
    assign fifo_level = r_level;
    assign we         = r_we;
    assign waddr      = r_waddr;
    assign wdata      = r_wdata;
    assign busy1      = r_pend[raddr1];
    assign busy2      = r_pend[raddr2];

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//   Directed bench for wb_arbiter. Expected regfile writes are queued as the
//   stimulus is issued; a monitor pops and compares on every cycle with we=1.
//   Status outputs (fifo_level, l_ready, busy) are compared directly.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p_valid;
    logic [4:0]  p_waddr;
    logic [31:0] p_wdata;
    logic        l_valid;
    logic        l_ready;
    logic [4:0]  l_waddr;
    logic [31:0] l_wdata;
    logic        claim_en;
    logic [4:0]  claim_addr;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        busy1;
    logic        busy2;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  fifo_level;

    int errors = 0;
    int checks = 0;

    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
        .clk        (clk),
        .rst        (rst_n),
        .p_valid    (p_valid),
        .p_waddr    (p_waddr),
        .p_wdata    (p_wdata),
        .l_valid    (l_valid),
        .l_ready    (l_ready),
        .l_waddr    (l_waddr),
        .l_wdata    (l_wdata),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .busy1      (busy1),
        .busy2      (busy2),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .fifo_level (fifo_level)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Write monitor: every regfile write must match the next queued entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && we === 1'b1) begin
            logic [36:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got waddr=%0d wdata=%0h expected no write", waddr, wdata);
            end else begin
                e = exp_q.pop_front();
                if ({waddr, wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got waddr=%0d wdata=%0h expected waddr=%0d wdata=%0h",
                             waddr, wdata, e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        p_valid    = 1'b0;
        p_waddr    = '0;
        p_wdata    = '0;
        l_valid    = 1'b0;
        l_waddr    = '0;
        l_wdata    = '0;
        claim_en   = 1'b0;
        claim_addr = '0;
        raddr1     = 5'd9;
        raddr2     = 5'd5;

        // Reset state
        tick(); tick();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_l_ready", 32'(l_ready), 32'd1);
        chk("rst_busy", 32'({busy1, busy2}), 32'd0);
        rst_n = 1'b1;
        tick();

        // P only: one-cycle latency, then idle
        p_valid = 1'b1; p_waddr = 5'd5; p_wdata = 32'hDEADBEEF;
        expect_wr(5'd5, 32'hDEADBEEF);
        tick();
        p_valid = 1'b0;
        chk("p_we_high", 32'(we), 32'd1);
        tick();
        chk("p_idle_we", 32'(we), 32'd0);
        chk("p_idle_hold_waddr", 32'(waddr), 32'd5);

        // Priority: P beats a waiting FIFO entry
        l_valid = 1'b1; l_waddr = 5'd7; l_wdata = 32'h11;
        tick();
        l_valid = 1'b0;
        p_valid = 1'b1; p_waddr = 5'd3; p_wdata = 32'hA;
        expect_wr(5'd3, 32'hA);
        tick();
        p_wdata = 32'hB;
        expect_wr(5'd3, 32'hB);
        tick();
        p_valid = 1'b0;
        expect_wr(5'd7, 32'h11);
        chk("prio_level1", 32'(fifo_level), 32'd1);
        tick();
        chk("prio_level0", 32'(fifo_level), 32'd0);
        tick();

        // Fill FIFO while P is continuously busy
        for (int k = 0; k < 4; k++) begin
            p_valid = 1'b1; p_waddr = 5'd1; p_wdata = 32'(k);
            l_valid = 1'b1; l_waddr = 5'(10 + k); l_wdata = 32'(32'h100 + k);
            expect_wr(5'd1, 32'(k));
            tick();
        end
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_l_ready", 32'(l_ready), 32'd0);
        p_wdata = 32'd4;
        l_waddr = 5'd20; l_wdata = 32'hBAD;
        expect_wr(5'd1, 32'd4);
        tick();
        chk("full_fifth_ignored", 32'(fifo_level), 32'd4);
        p_valid = 1'b0; l_valid = 1'b0;
        for (int k = 0; k < 4; k++) expect_wr(5'(10 + k), 32'(32'h100 + k));
        tick();
        chk("drain_l_ready", 32'(l_ready), 32'd1);
        chk("drain_level3", 32'(fifo_level), 32'd3);
        tick(); tick(); tick();
        chk("drain_level0", 32'(fifo_level), 32'd0);
        tick();

        // Scoreboard: claim, then long-latency retire clears busy with we
        raddr1 = 5'd9;
        claim_en = 1'b1; claim_addr = 5'd9;
        tick();
        claim_en = 1'b0;
        chk("sb_busy_set", 32'(busy1), 32'd1);
        l_valid = 1'b1; l_waddr = 5'd9; l_wdata = 32'h99;
        expect_wr(5'd9, 32'h99);
        tick();
        l_valid = 1'b0;
        chk("sb_busy_while_queued", 32'(busy1), 32'd1);
        tick();
        chk("sb_clear_we", 32'(we), 32'd1);
        chk("sb_clear_waddr", 32'(waddr), 32'd9);
        chk("sb_busy_clear", 32'(busy1), 32'd0);

        // Same-edge set and clear: set wins
        claim_en = 1'b1; claim_addr = 5'd9;
        tick();
        p_valid = 1'b1; p_waddr = 5'd9; p_wdata = 32'h55;
        expect_wr(5'd9, 32'h55);
        tick();
        p_valid = 1'b0; claim_en = 1'b0;
        chk("coll_we", 32'(we), 32'd1);
        chk("coll_busy_kept", 32'(busy1), 32'd1);
        p_valid = 1'b1; p_wdata = 32'h56;
        expect_wr(5'd9, 32'h56);
        tick();
        p_valid = 1'b0;
        chk("coll_busy_cleared", 32'(busy1), 32'd0);

        // busy2 port
        raddr2 = 5'd12;
        claim_en = 1'b1; claim_addr = 5'd12;
        tick();
        claim_en = 1'b0;
        chk("busy2_set", 32'({busy1, busy2}), 32'b01);
        p_valid = 1'b1; p_waddr = 5'd12; p_wdata = 32'hC;
        expect_wr(5'd12, 32'hC);
        tick();
        p_valid = 1'b0;
        chk("busy2_clear", 32'(busy2), 32'd0);

        // Register 0: consumed, no write, never pending
        p_valid = 1'b1; p_waddr = 5'd0; p_wdata = 32'h77;
        tick();
        p_valid = 1'b0;
        chk("r0_we", 32'(we), 32'd0);
        raddr1 = 5'd0;
        claim_en = 1'b1; claim_addr = 5'd0;
        tick();
        claim_en = 1'b0;
        chk("r0_busy", 32'(busy1), 32'd0);

        // Async reset with three entries queued and one pending register
        raddr1 = 5'd14;
        claim_en = 1'b1; claim_addr = 5'd14;
        for (int k = 0; k < 3; k++) begin
            p_valid = 1'b1; p_waddr = 5'd2; p_wdata = 32'(32'h200 + k);
            l_valid = 1'b1; l_waddr = 5'(14 + k); l_wdata = 32'(32'h300 + k);
            expect_wr(5'd2, 32'(32'h200 + k));
            tick();
            claim_en = 1'b0;
        end
        p_valid = 1'b0; l_valid = 1'b0;
        chk("pre_rst_level", 32'(fifo_level), 32'd3);
        chk("pre_rst_busy", 32'(busy1), 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(fifo_level), 32'd0);
        chk("arst_we", 32'(we), 32'd0);
        chk("arst_l_ready", 32'(l_ready), 32'd1);
        chk("arst_busy", 32'({busy1, busy2}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("post_rst_we", 32'(we), 32'd0);
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
